// File: rtl/lu_result_demux.sv
`default_nettype none
// ============================================================================
// Module   : lu_result_demux
// Summary  : Splits the shared LU result line back into registered OR/NOR
//            lanes, pairs them and flags non-complementary or orphaned lanes.
// Revision : 1.0 - initial release
// ============================================================================
module lu_result_demux #(
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   output logic             in_ready,
   output logic [WIDTH-1:0] or_q,
   output logic [WIDTH-1:0] nor_q,
   output logic             pair_valid,
   output logic             mismatch,
   output logic             timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
   localparam logic [WIDTH-1:0] c_all_ones = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_HAVE_OR  = 2'd1,
      ST_HAVE_NOR = 2'd2,
      ST_PAIR     = 2'd3
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_or_q;
   logic [WIDTH-1:0] r_nor_q;
   logic             r_pair_valid;
   logic             r_mismatch;
   logic             r_timeout_err;

   logic             w_ready;
   logic             w_xfer;
   logic             w_xfer_or;
   logic             w_xfer_nor;
   logic [WIDTH-1:0] w_next_or;
   logic [WIDTH-1:0] w_next_nor;
   logic             w_next_mismatch;
   logic             w_expired;

   // PAIR is the only state that refuses a beat; reset forces ready low.
   assign w_ready    = ~reset & (r_state != ST_PAIR);
   assign w_xfer     = in_valid & w_ready;
   assign w_xfer_or  = w_xfer & in_sel;
   assign w_xfer_nor = w_xfer & ~in_sel;

   // Mismatch is judged on the lane values that will be held in the PAIR cycle.
   assign w_next_or       = w_xfer_or  ? in_data : r_or_q;
   assign w_next_nor      = w_xfer_nor ? in_data : r_nor_q;
   assign w_next_mismatch = ((w_next_or ^ w_next_nor) != c_all_ones);

   assign w_expired = ~w_xfer & (r_cnt == c_cnt_last);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_or_q        <= '0;
         r_nor_q       <= '0;
         r_pair_valid  <= 1'b0;
         r_mismatch    <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_pair_valid  <= 1'b0;
         r_mismatch    <= 1'b0;
         r_timeout_err <= 1'b0;

         if (w_xfer_or) begin
            r_or_q <= in_data;
         end
         if (w_xfer_nor) begin
            r_nor_q <= in_data;
         end

         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (w_xfer_or) begin
                  r_state <= ST_HAVE_OR;
               end else if (w_xfer_nor) begin
                  r_state <= ST_HAVE_NOR;
               end
            end

            ST_HAVE_OR, ST_HAVE_NOR: begin
               if ((w_xfer_nor && r_state == ST_HAVE_OR) ||
                   (w_xfer_or  && r_state == ST_HAVE_NOR)) begin
                  r_state      <= ST_PAIR;
                  r_cnt        <= '0;
                  r_pair_valid <= 1'b1;
                  r_mismatch   <= w_next_mismatch;
               end else if (w_xfer) begin
                  // Same-lane repeat: value already overwritten above, wait restarts.
                  r_cnt <= '0;
               end else if (w_expired) begin
                  r_state       <= ST_IDLE;
                  r_cnt         <= '0;
                  r_timeout_err <= 1'b1;
               end else if (r_cnt != c_cnt_max) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            ST_PAIR: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end

            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign in_ready    = w_ready;
   assign or_q        = r_or_q;
   assign nor_q       = r_nor_q;
   assign pair_valid  = r_pair_valid;
   assign mismatch    = r_mismatch;
   assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_lu_result_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_lu_result_demux
// Summary  : Directed self-checking bench for lu_result_demux.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lu_result_demux;

   localparam int WIDTH   = 4;
   localparam int TIMEOUT = 15;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             in_ready;
   logic [WIDTH-1:0] or_q;
   logic [WIDTH-1:0] nor_q;
   logic             pair_valid;
   logic             mismatch;
   logic             timeout_err;

   int total = 0;
   int bad   = 0;

   lu_result_demux #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_ready   (in_ready),
      .or_q       (or_q),
      .nor_q      (nor_q),
      .pair_valid (pair_valid),
      .mismatch   (mismatch),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; everything after returns 1ns past the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic sel, input logic [WIDTH-1:0] data);
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = data;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
      step();
      total++; if (or_q !== 4'h0) begin bad++; $display("FAIL reset_or_q: got %b want 0000", or_q); end
      total++; if (nor_q !== 4'h0) begin bad++; $display("FAIL reset_nor_q: got %b want 0000", nor_q); end
      total++; if ({pair_valid, mismatch, timeout_err} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {pair_valid, mismatch, timeout_err}); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", in_ready); end
      reset = 1'b0;
      step();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_or_then_nor();
      send(1'b1, 4'b1110);
      total++; if (pair_valid !== 1'b0) begin bad++; $display("FAIL t1_half_pv: got %b want 0", pair_valid); end
      send(1'b0, 4'b0001);
      total++; if (pair_valid !== 1'b1) begin bad++; $display("FAIL t1_pv: got %b want 1", pair_valid); end
      total++; if (or_q !== 4'b1110) begin bad++; $display("FAIL t1_or_q: got %b want 1110", or_q); end
      total++; if (nor_q !== 4'b0001) begin bad++; $display("FAIL t1_nor_q: got %b want 0001", nor_q); end
      total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL t1_mismatch: got %b want 0", mismatch); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL t1_pair_ready: got %b want 0", in_ready); end
      step();
      total++; if (pair_valid !== 1'b0) begin bad++; $display("FAIL t1_pv_pulse: got %b want 0", pair_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL t1_idle_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_nor_then_or();
      send(1'b0, 4'b0000);
      send(1'b1, 4'b1011);
      total++; if (pair_valid !== 1'b1) begin bad++; $display("FAIL t2_pv: got %b want 1", pair_valid); end
      total++; if (mismatch !== 1'b1) begin bad++; $display("FAIL t2_mismatch: got %b want 1", mismatch); end
      total++; if (or_q !== 4'b1011) begin bad++; $display("FAIL t2_or_q: got %b want 1011", or_q); end
      total++; if (nor_q !== 4'b0000) begin bad++; $display("FAIL t2_nor_q: got %b want 0000", nor_q); end
      step();
      total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL t2_mismatch_clr: got %b want 0", mismatch); end
   endtask

   task automatic test_overwrite();
      send(1'b1, 4'b0101);
      total++; if (or_q !== 4'b0101) begin bad++; $display("FAIL t3_or_first: got %b want 0101", or_q); end
      send(1'b1, 4'b1010);
      total++; if ({pair_valid, timeout_err} !== 2'b00) begin bad++; $display("FAIL t3_repeat_flags: got %b want 00", {pair_valid, timeout_err}); end
      total++; if (or_q !== 4'b1010) begin bad++; $display("FAIL t3_or_over: got %b want 1010", or_q); end
      send(1'b0, 4'b0101);
      total++; if (pair_valid !== 1'b1) begin bad++; $display("FAIL t3_pv: got %b want 1", pair_valid); end
      total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL t3_mismatch: got %b want 0", mismatch); end
      step();
      total++; if ({pair_valid, timeout_err} !== 2'b00) begin bad++; $display("FAIL t3_after_flags: got %b want 00", {pair_valid, timeout_err}); end
   endtask

   task automatic test_timeout();
      int early;
      early = 0;
      send(1'b1, 4'b1111);
      for (int i = 1; i < TIMEOUT; i++) begin
         step();
         if (timeout_err !== 1'b0 || pair_valid !== 1'b0) early++;
      end
      total++; if (early != 0) begin bad++; $display("FAIL t4_early_flags: got %0d cycles with a flag want 0", early); end
      step();
      total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL t4_timeout: got %b want 1", timeout_err); end
      total++; if (pair_valid !== 1'b0) begin bad++; $display("FAIL t4_timeout_pv: got %b want 0", pair_valid); end
      step();
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL t4_timeout_pulse: got %b want 0", timeout_err); end
      // Back in IDLE: a lone NOR must not complete a pair with the expired OR.
      send(1'b0, 4'b0000);
      total++; if (pair_valid !== 1'b0) begin bad++; $display("FAIL t4_idle_after: got %b want 0", pair_valid); end
      send(1'b1, 4'b1111);
      total++; if (pair_valid !== 1'b1) begin bad++; $display("FAIL t4_repair_pv: got %b want 1", pair_valid); end
      step();
   endtask

   task automatic test_expiry_transfer_wins();
      send(1'b1, 4'b1100);
      for (int i = 1; i < TIMEOUT; i++) step();
      send(1'b0, 4'b0011);
      total++; if (pair_valid !== 1'b1) begin bad++; $display("FAIL t4b_pv: got %b want 1", pair_valid); end
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL t4b_timeout: got %b want 0", timeout_err); end
      total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL t4b_mismatch: got %b want 0", mismatch); end
      step();
   endtask

   task automatic test_back_to_back();
      send(1'b1, 4'b0011);
      in_valid = 1'b1; in_sel = 1'b0; in_data = 4'b1100;
      step();
      total++; if (pair_valid !== 1'b1) begin bad++; $display("FAIL t5_pv: got %b want 1", pair_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL t5_ready: got %b want 0", in_ready); end
      in_sel = 1'b1; in_data = 4'b0110;
      step();
      total++; if (or_q !== 4'b0011) begin bad++; $display("FAIL t5_not_consumed: got %b want 0011", or_q); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL t5_idle_ready: got %b want 1", in_ready); end
      step();
      in_valid = 1'b0;
      total++; if (or_q !== 4'b0110) begin bad++; $display("FAIL t5_accepted: got %b want 0110", or_q); end
      total++; if (pair_valid !== 1'b0) begin bad++; $display("FAIL t5_no_pair: got %b want 0", pair_valid); end
      // Drain the held OR lane with its complement.
      send(1'b0, 4'b1001);
      total++; if ({pair_valid, mismatch} !== 2'b10) begin bad++; $display("FAIL t5_drain: got %b want 10", {pair_valid, mismatch}); end
      step();
   endtask

   task automatic test_reset_mid_wait();
      send(1'b0, 4'b0011);
      total++; if (nor_q !== 4'b0011) begin bad++; $display("FAIL t6_nor_held: got %b want 0011", nor_q); end
      #1 reset = 1'b1;
      #1;
      total++; if (or_q !== 4'h0 || nor_q !== 4'h0) begin bad++; $display("FAIL t6_async_lanes: got %b/%b want 0000/0000", or_q, nor_q); end
      total++; if ({pair_valid, mismatch, timeout_err, in_ready} !== 4'b0000) begin bad++; $display("FAIL t6_async_flags: got %b want 0000", {pair_valid, mismatch, timeout_err, in_ready}); end
      step();
      reset = 1'b0;
      step();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL t6_release_ready: got %b want 1", in_ready); end
      send(1'b1, 4'b1001);
      total++; if (pair_valid !== 1'b0) begin bad++; $display("FAIL t6_or_alone_pv: got %b want 0", pair_valid); end
      total++; if (or_q !== 4'b1001 || nor_q !== 4'b0000) begin bad++; $display("FAIL t6_lanes: got %b/%b want 1001/0000", or_q, nor_q); end
      step();
      total++; if ({pair_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL t6_have_or: got %b want 01", {pair_valid, in_ready}); end
   endtask

   initial begin
      test_reset();
      test_or_then_nor();
      test_nor_then_or();
      test_overwrite();
      test_timeout();
      test_expiry_transfer_wins();
      test_back_to_back();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
